// File: rtl/led_pattern_engine_if.sv
// Host-side bundle for the LED pattern engine: control inputs and the
// registered LED bank with its step/wrap strobes.
interface led_pattern_engine_if #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 16
);
  logic             ena;
  logic [2:0]       mode;
  logic [DIV_W-1:0] rate;
  logic             pause;
  logic             step_req;
  logic [WIDTH-1:0] leds;
  logic             step_strobe;
  logic             wrap;

  // Host side: drives the controls, watches the LEDs and strobes
  modport master (
    output ena, mode, rate, pause, step_req,
    input  leds, step_strobe, wrap
  );

  // Engine side
  modport slave (
    input  ena, mode, rate, pause, step_req,
    output leds, step_strobe, wrap
  );
endinterface

// File: rtl/led_pattern_engine.sv
// LED pattern engine: six animations (count, bounce, LFSR, alternate, fill,
// Gray) plus hold, stepped by a programmable prescaler or by single-step
// requests while paused. All outputs are registered.
module led_pattern_engine #(
  parameter int               WIDTH     = 8,
  parameter int               DIV_W     = 16,
  parameter logic [WIDTH-1:0] LFSR_TAPS = 8'hB8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  led_pattern_engine_if.slave  bus
);

  typedef enum logic [2:0] {
    M_COUNT  = 3'b000,
    M_BOUNCE = 3'b001,
    M_LFSR   = 3'b010,
    M_ALT    = 3'b011,
    M_FILL   = 3'b100,
    M_GRAY   = 3'b101,
    M_HOLD0  = 3'b110,
    M_HOLD1  = 3'b111
  } mode_e;

  typedef enum logic { DIR_UP = 1'b0, DIR_DOWN = 1'b1 } dir_e;
  typedef enum logic { PH_FILL = 1'b0, PH_EMPTY = 1'b1 } ph_e;

  // 0101..01 with bit0 set, for any WIDTH
  function automatic logic [WIDTH-1:0] alt_seed();
    logic [WIDTH-1:0] p;
    for (int i = 0; i < WIDTH; i++) p[i] = ~i[0];
    return p;
  endfunction

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ALT_SEED = alt_seed();

  mode_e            mode_q;
  dir_e             dir_q;
  ph_e              ph_q;
  logic [DIV_W-1:0] div_q;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] leds_q;
  logic             strobe_q;
  logic             wrap_q;

  logic             mode_chg;
  logic             step;
  logic [DIV_W-1:0] nxt_div;
  logic [WIDTH-1:0] nxt_leds;
  logic [WIDTH-1:0] nxt_bin;
  logic [WIDTH-1:0] bin_inc;
  dir_e             nxt_dir;
  ph_e              nxt_ph;
  logic             nxt_wrap;
  logic             one_hot;

  assign bus.leds        = leds_q;
  assign bus.step_strobe = strobe_q;
  assign bus.wrap        = wrap_q;

  // Step decision, prescaler advance and next pattern for the current mode
  always_comb begin
    mode_chg = (bus.mode != mode_q);
    step     = bus.pause ? bus.step_req : (div_q == bus.rate);
    nxt_div  = div_q;
    if (!bus.pause) nxt_div = step ? '0 : div_q + DIV_W'(1);

    nxt_leds = leds_q;
    nxt_dir  = dir_q;
    nxt_ph   = ph_q;
    nxt_bin  = bin_q;
    nxt_wrap = 1'b0;
    bin_inc  = bin_q + WIDTH'(1);
    one_hot  = (leds_q != '0) && ((leds_q & (leds_q - WIDTH'(1))) == '0);

    case (mode_q)
      M_COUNT: begin
        nxt_leds = leds_q + WIDTH'(1);
        nxt_wrap = (nxt_leds == '0);
      end
      M_BOUNCE: begin
        if (!one_hot) begin
          // Corrupted bank: restart the sweep from the bottom
          nxt_leds = ONE;
          nxt_dir  = DIR_UP;
        end else if (dir_q == DIR_UP) begin
          if (leds_q[WIDTH-1]) begin
            nxt_leds = leds_q >> 1;
            nxt_dir  = DIR_DOWN;
          end else begin
            nxt_leds = leds_q << 1;
          end
        end else begin
          if (leds_q[0]) begin
            nxt_leds = leds_q << 1;
            nxt_dir  = DIR_UP;
          end else begin
            nxt_leds = leds_q >> 1;
            nxt_wrap = (nxt_leds == ONE);
          end
        end
      end
      M_LFSR: begin
        if (leds_q == '0) nxt_leds = ONE;
        else nxt_leds = (leds_q >> 1) ^ (leds_q[0] ? LFSR_TAPS : '0);
        nxt_wrap = (nxt_leds == ONE);
      end
      M_ALT: begin
        nxt_leds = ~leds_q;
        nxt_wrap = (nxt_leds == ALT_SEED);
      end
      M_FILL: begin
        if (ph_q == PH_FILL) begin
          nxt_leds = {leds_q[WIDTH-2:0], 1'b1};
          if (nxt_leds == ALL_ONES) nxt_ph = PH_EMPTY;
        end else begin
          nxt_leds = {leds_q[WIDTH-2:0], 1'b0};
          if (nxt_leds == '0) begin
            nxt_ph   = PH_FILL;
            nxt_wrap = 1'b1;
          end
        end
      end
      M_GRAY: begin
        nxt_bin  = bin_inc;
        nxt_leds = bin_inc ^ (bin_inc >> 1);
        nxt_wrap = (bin_inc == '0);
      end
      default: ;
    endcase
  end

  // Mode register, seeding on mode change, stepping and strobe generation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= M_COUNT;
      div_q    <= '0;
      dir_q    <= DIR_UP;
      ph_q     <= PH_FILL;
      bin_q    <= '0;
      leds_q   <= '0;
      strobe_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else if (!bus.ena) begin
      strobe_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else if (mode_chg) begin
      mode_q   <= mode_e'(bus.mode);
      div_q    <= '0;
      strobe_q <= 1'b0;
      wrap_q   <= 1'b0;
      case (mode_e'(bus.mode))
        M_COUNT:  leds_q <= '0;
        M_BOUNCE: begin
          leds_q <= ONE;
          dir_q  <= DIR_UP;
        end
        M_LFSR:   leds_q <= ONE;
        M_ALT:    leds_q <= ALT_SEED;
        M_FILL:   begin
          leds_q <= '0;
          ph_q   <= PH_FILL;
        end
        M_GRAY:   begin
          leds_q <= '0;
          bin_q  <= '0;
        end
        default:  ;
      endcase
    end else begin
      div_q    <= nxt_div;
      strobe_q <= step;
      wrap_q   <= step & nxt_wrap;
      if (step) begin
        leds_q <= nxt_leds;
        dir_q  <= nxt_dir;
        ph_q   <= nxt_ph;
        bin_q  <= nxt_bin;
      end
    end
  end

endmodule
